dummy_adc_frontend: RTL and testbench

Behavioural stand-in for the mixed-signal ADC front end: a PLL model, an analog mux model and an ADC model combined in one synchronous block. It is driven by the ADC APB wrapper's three write registers (PLL control, mux select, trigger). It returns a 32-bit status word and a 32-bit measurement word for APB readback. Analog inputs are synthetic, so results are deterministic and checkable in simulation.

---
 rtl/dummy_adc_frontend.sv | 186 ++++++++++++++++++
 tb/tb_dummy_adc_frontend.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dummy_adc_frontend.sv
// dummy_adc_frontend
//   Behavioural stand-in for the mixed-signal ADC front end: PLL lock model,
//   sample-tick divider, analog mux with synthetic channel values and a
//   successive-tick ADC conversion model. Fully synchronous to clk.
//
// Ports
//   clk          single clock (PCLK)
//   reset        asynchronous active-low reset (PRESETn)
//   PLL_CONTROL  [0]=PLL enable, [11:8]=sample tick divider DIV
//   INPUT_SEL    [log2(NUM_CH)-1:0]=mux channel
//   ADC_TRIGGER  [0]=conversion start, rising-edge sensitive
//   STATUS       [0] busy [1] done [2] locked [3] overrun [4] error
//                [10:8] latched channel [23:16] conversion count
//   MEASUREMENT  last completed result, zero-extended from ADC_BITS
module dummy_adc_frontend #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADC_BITS    = 12,
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] PLL_CONTROL,
  input  logic [DATA_WIDTH-1:0] INPUT_SEL,
  input  logic [DATA_WIDTH-1:0] ADC_TRIGGER,
  output logic [DATA_WIDTH-1:0] STATUS,
  output logic [DATA_WIDTH-1:0] MEASUREMENT
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned BIT_W  = $clog2(ADC_BITS);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_e;

  state_e              state_q, state_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                locked_q, locked_d;
  logic [3:0]          div_q, div_d;
  logic [3:0]          div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                trig_prev_q;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                error_q, error_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADC_BITS-1:0] sample_q, sample_d;
  logic [ADC_BITS-1:0] meas_q, meas_d;
  logic [7:0]          conv_cnt_q, conv_cnt_d;

  logic                pll_en;
  logic                trig_rise;
  logic                tick;
  logic [CH_W-1:0]     ch_sel;
  logic [ADC_BITS-1:0] synth_val;
  logic                unused_bits;

  assign pll_en    = PLL_CONTROL[0];
  assign ch_sel    = INPUT_SEL[CH_W-1:0];
  assign trig_rise = ADC_TRIGGER[0] & ~trig_prev_q;
  assign tick      = locked_q && (div_cnt_q == div_q);
  assign synth_val = (ADC_BITS'(ch_sel) << (ADC_BITS - 3)) + ADC_BITS'(conv_cnt_q);

  assign unused_bits = ^{PLL_CONTROL[DATA_WIDTH-1:12], PLL_CONTROL[7:1],
                         INPUT_SEL[DATA_WIDTH-1:CH_W], ADC_TRIGGER[DATA_WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
    error_d    = error_q;
    ch_d       = ch_q;
    sample_d   = sample_q;
    meas_d     = meas_q;
    conv_cnt_d = conv_cnt_q;

    // PLL lock: saturating count of enabled clocks
    if (!pll_en) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      if (lock_cnt_q != LOCK_W'(LOCK_CYCLES)) begin
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
      locked_d = (lock_cnt_d == LOCK_W'(LOCK_CYCLES));
    end

    // Tick divider: DIV is only sampled at a wrap so a change never
    // shortens or stretches the period in flight
    if (!locked_q || tick) begin
      div_cnt_d = '0;
      div_d     = PLL_CONTROL[11:8];
    end else begin
      div_cnt_d = div_cnt_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          if (locked_q && pll_en) begin
            state_d   = S_CONV;
            ch_d      = ch_sel;
            sample_d  = synth_val;
            done_d    = 1'b0;
            error_d   = 1'b0;
            overrun_d = 1'b0;
            bit_cnt_d = '0;
            // acceptance restarts the divider so the first tick lands DIV+1 clocks later
            div_cnt_d = '0;
            div_d     = PLL_CONTROL[11:8];
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_CONV: begin
        if (trig_rise) begin
          overrun_d = 1'b1;
        end
        if (!pll_en) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          error_d = 1'b1;
        end else if (tick) begin
          if (bit_cnt_q == BIT_W'(ADC_BITS - 1)) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            meas_d     = sample_q;
            conv_cnt_d = conv_cnt_q + 8'd1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      div_q       <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      trig_prev_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      error_q     <= 1'b0;
      ch_q        <= '0;
      sample_q    <= '0;
      meas_q      <= '0;
      conv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      div_q       <= div_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      trig_prev_q <= ADC_TRIGGER[0];
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      error_q     <= error_d;
      ch_q        <= ch_d;
      sample_q    <= sample_d;
      meas_q      <= meas_d;
      conv_cnt_q  <= conv_cnt_d;
    end
  end

  assign STATUS = DATA_WIDTH'({conv_cnt_q, 5'b0, 3'(ch_q), 3'b0,
                               error_q, overrun_q, locked_q, done_q,
                               (state_q == S_CONV)});
  assign MEASUREMENT = DATA_WIDTH'(meas_q);

endmodule

// File: tb/tb_dummy_adc_frontend.sv
module tb_dummy_adc_frontend;

  logic        clk;
  logic        reset;
  logic [31:0] PLL_CONTROL;
  logic [31:0] INPUT_SEL;
  logic [31:0] ADC_TRIGGER;
  logic [31:0] STATUS;
  logic [31:0] MEASUREMENT;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned model_cnt = 0;
  logic [31:0] exp_q[$];

  dummy_adc_frontend #(
    .DATA_WIDTH (32),
    .ADC_BITS   (12),
    .NUM_CH     (8),
    .LOCK_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PLL_CONTROL(PLL_CONTROL),
    .INPUT_SEL  (INPUT_SEL),
    .ADC_TRIGGER(ADC_TRIGGER),
    .STATUS     (STATUS),
    .MEASUREMENT(MEASUREMENT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // rising edge on ADC_TRIGGER[0]; returns just after the edge that samples it
  task automatic fire(int unsigned ch);
    INPUT_SEL   = ch;
    ADC_TRIGGER = 32'd0;
    step();
    ADC_TRIGGER = 32'd1;
    step();
  endtask

  task automatic push_exp(int unsigned ch);
    exp_q.push_back(((ch << 9) + model_cnt) & 32'hFFF);
  endtask

  task automatic wait_done(string tag, int unsigned lat);
    int unsigned n = 0;
    logic [31:0] e;
    while (STATUS[1] !== 1'b1 && n < lat + 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
    check({tag, "_meas"}, MEASUREMENT, e);
    model_cnt = (model_cnt + 1) % 256;
    check({tag, "_cnt"}, {24'd0, STATUS[23:16]}, model_cnt);
  endtask

  initial begin
    // 1: reset with arbitrary inputs, then lock timing
    reset       = 1'b0;
    PLL_CONTROL = 32'h1;
    INPUT_SEL   = 32'h5;
    ADC_TRIGGER = 32'h1;
    step(3);
    check("rst_status", STATUS, 32'h0);
    check("rst_meas", MEASUREMENT, 32'h0);
    // trigger held high through reset looks like a fresh edge while unlocked
    reset = 1'b1;
    step(15);
    check("lock_15", STATUS, 32'h10);
    step();
    check("lock_16", STATUS, 32'h14);
    ADC_TRIGGER = 32'h0;

    // 2: first conversion, DIV=0, channel 3
    fire(3);
    push_exp(3);
    check("conv1_busy", STATUS, 32'h0000_0305);
    wait_done("conv1", 12);
    check("conv1_status", STATUS, 32'h0001_0306);

    // 3: repeat on channel 3, then DIV=3
    fire(3);
    push_exp(3);
    wait_done("conv2", 12);
    PLL_CONTROL = 32'h301;
    step();
    check("div_no_relock", {31'd0, STATUS[2]}, 32'd1);
    fire(3);
    push_exp(3);
    wait_done("conv3_div3", 48);
    check("conv3_status", STATUS, 32'h0003_0306);

    // 4: trigger while unlocked, then overrun
    PLL_CONTROL = 32'h0;
    step(2);
    fire(1);
    check("unlocked_status", STATUS, 32'h0003_0312);
    check("unlocked_meas", MEASUREMENT, 32'h602);
    PLL_CONTROL = 32'h1;
    step(16);
    check("relock", {31'd0, STATUS[2]}, 32'd1);
    fire(2);
    push_exp(2);
    check("ovr_busy", STATUS, 32'h0003_0205);
    step(3);
    fire(2);
    check("ovr_flag", STATUS, 32'h0003_020D);
    wait_done("ovr_conv", 7);
    check("ovr_status", STATUS, 32'h0004_020E);

    // 5: PLL disable mid-conversion aborts
    fire(1);
    push_exp(1);
    check("abort_busy", STATUS, 32'h0004_0105);
    step(2);
    INPUT_SEL = 32'h6;
    step(2);
    PLL_CONTROL = 32'h0;
    step();
    void'(exp_q.pop_front());
    check("abort_status", STATUS, 32'h0004_0110);
    check("abort_meas", MEASUREMENT, 32'h403);
    PLL_CONTROL = 32'h1;
    step(16);
    check("relock2", {31'd0, STATUS[2]}, 32'd1);

    // 5b: INPUT_SEL change mid-conversion is ignored
    fire(5);
    push_exp(5);
    step(3);
    INPUT_SEL = 32'h0;
    wait_done("latch_ch", 9);
    check("latch_ch_field", {29'd0, STATUS[10:8]}, 32'd5);

    // 6: reset mid-conversion clears outputs without a clock edge
    fire(7);
    step(4);
    reset = 1'b0;
    #1;
    check("midrst_status", STATUS, 32'h0);
    check("midrst_meas", MEASUREMENT, 32'h0);
    exp_q.delete();
    model_cnt   = 0;
    ADC_TRIGGER = 32'h0;
    step(2);
    reset = 1'b1;
    step(16);
    check("relock3", STATUS, 32'h4);

    // 6b: 256 conversions wrap the count to zero
    for (int i = 0; i < 256; i++) begin
      fire(i % 8);
      push_exp(i % 8);
      wait_done("wrap", 12);
    end
    check("wrap_zero", {24'd0, STATUS[23:16]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
